// File: rtl/uart_tx_fifo.sv
// UART transmitter with a valid/ready byte FIFO and configurable frame format.
// Frames are START, DATA_BITS data bits (LSB first), optional parity bit, then STOP_BITS stop bits.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tx_en,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          txd,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int STOP_LEN = STOP_BITS * CLKS_PER_BIT;
  localparam int BAUD_W   = $clog2(STOP_LEN);
  localparam int IDX_W    = $clog2(DATA_BITS);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be in 5..8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two in 2..16");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count_q;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

  logic full, push, pop, bit_end, stop_end, par_bit;

  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign bit_end  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign stop_end = (state_q == S_STOP) && (baud_q == BAUD_W'(STOP_LEN - 1));
  // A new frame may start from idle or seamlessly from the last stop cycle.
  assign pop      = (state_q == S_IDLE || stop_end) && tx_en && (count_q != '0);
  assign par_bit  = (^shift_q) ^ (PARITY == 1);

  assign busy       = (state_q != S_IDLE);
  assign tx_done    = stop_end;
  assign fifo_count = count_q;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BAUD_W'(1);
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (pop) state_d = S_START;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          baud_d  = '0;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          baud_d  = '0;
        end
      end
      S_STOP: begin
        if (stop_end) begin
          baud_d  = '0;
          state_d = pop ? S_START : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
      end
    endcase
  end

  always_comb begin
    txd = 1'b1;
    unique case (state_q)
      S_START:  txd = 1'b0;
      S_DATA:   txd = shift_q[idx_q];
      S_PARITY: txd = par_bit;
      default:  txd = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        shift_q <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (!push && pop) count_q <= count_q - CNT_W'(1);
    end
  end

  // NOTE: the storage array has no reset; entries are only read after being written, and the pointers reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data[DATA_BITS-1:0];
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: five frame formats share one stimulus stream and are
// checked against spec constants and a frame-position reference model.
module tb_uart_tx_fifo;

  localparam int NI    = 5;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  // Instances: 8N1, 8E1, 8O1, 7N1, 8N2
  localparam int DB [NI] = '{8, 8, 8, 7, 8};
  localparam int PR [NI] = '{0, 2, 1, 0, 0};
  localparam int SB [NI] = '{1, 1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_en = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;

  logic       txd_w  [NI];
  logic       busy_w [NI];
  logic       done_w [NI];
  logic       rdy_w  [NI];
  logic [2:0] cnt_w  [NI];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_fifo #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (DB[g]),
      .PARITY      (PR[g]),
      .STOP_BITS   (SB[g]),
      .FIFO_DEPTH  (DEPTH)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tx_en     (tx_en),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (rdy_w[g]),
      .txd       (txd_w[g]),
      .busy      (busy_w[g]),
      .tx_done   (done_w[g]),
      .fifo_count(cnt_w[g])
    );
  end

  // Reference model: a byte queue plus the position inside the frame currently on the line.
  logic [7:0] m_q   [NI][DEPTH];
  int         m_size[NI];
  bit         m_act [NI];
  int         m_pos [NI];
  logic [7:0] m_cur [NI];

  function automatic int flen(input int i);
    return (1 + DB[i] + ((PR[i] != 0) ? 1 : 0) + SB[i]) * CPB;
  endfunction

  function automatic logic exp_txd(input int i);
    int b;
    logic [7:0] m;
    if (!m_act[i]) return 1'b1;
    b = m_pos[i] / CPB;
    m = m_cur[i] & 8'((1 << DB[i]) - 1);
    if (b == 0) return 1'b0;
    if (b <= DB[i]) return m[b-1];
    if (PR[i] != 0 && b == DB[i] + 1) return (^m) ^ (PR[i] == 1);
    return 1'b1;
  endfunction

  function automatic logic exp_done(input int i);
    return m_act[i] && (m_pos[i] == flen(i) - 1);
  endfunction

  // Advance the model with the inputs present before the edge, then step past the edge.
  task automatic tick();
    bit push, pop;
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        m_size[i] = 0;
        m_act[i]  = 1'b0;
        m_pos[i]  = 0;
      end else begin
        push = in_valid && (m_size[i] < DEPTH);
        pop  = (!m_act[i] || m_pos[i] == flen(i) - 1) && tx_en && (m_size[i] > 0);
        if (m_act[i]) begin
          if (m_pos[i] == flen(i) - 1) m_act[i] = 1'b0;
          else m_pos[i]++;
        end
        if (pop) begin
          m_cur[i] = m_q[i][0];
          for (int k = 0; k < DEPTH - 1; k++) m_q[i][k] = m_q[i][k+1];
          m_size[i]--;
          m_act[i] = 1'b1;
          m_pos[i] = 0;
        end
        if (push) begin
          m_q[i][m_size[i]] = in_data;
          m_size[i]++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Line recorder used by the directed tests.
  logic rec_txd [NI][256];
  int   rec_busy[NI], rec_done[NI], rec_done_at[NI], rec_fall[NI], rec_low[NI];

  task automatic run_cycles(input int n);
    logic prev [NI];
    for (int i = 0; i < NI; i++) begin
      rec_busy[i] = 0; rec_done[i] = 0; rec_done_at[i] = -1; rec_fall[i] = 0; rec_low[i] = 0;
      prev[i] = busy_w[i];
    end
    for (int c = 0; c < n; c++) begin
      tick();
      for (int i = 0; i < NI; i++) begin
        if (c < 256) rec_txd[i][c] = txd_w[i];
        if (busy_w[i]) rec_busy[i]++;
        if (!txd_w[i]) rec_low[i]++;
        if (done_w[i]) begin rec_done[i]++; rec_done_at[i] = c; end
        if (prev[i] && !busy_w[i]) rec_fall[i]++;
        prev[i] = busy_w[i];
      end
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tx_en = 1'b1; in_valid = 1'b0;
    tick(); tick();
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if (txd_w[i] !== 1'b1 || busy_w[i] !== 1'b0 || done_w[i] !== 1'b0 ||
          cnt_w[i] !== 3'd0 || rdy_w[i] !== 1'b1) begin
        n_bad++;
        $display("FAIL reset inst%0d: txd=%b busy=%b done=%b cnt=%0d rdy=%b, required 1 0 0 0 1",
                 i, txd_w[i], busy_w[i], done_w[i], cnt_w[i], rdy_w[i]);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_8n1_frame();
    logic [9:0] bits;
    bits = {1'b1, 8'hA5, 1'b0};
    push_byte(8'hA5);
    n_cmp++;
    if (busy_w[0] !== 1'b0 || txd_w[0] !== 1'b1 || cnt_w[0] !== 3'd1) begin
      n_bad++;
      $display("FAIL accept_edge: busy=%b txd=%b cnt=%0d, required 0 1 1", busy_w[0], txd_w[0], cnt_w[0]);
    end
    run_cycles(50);
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < CPB; j++) begin
        n_cmp++;
        if (rec_txd[0][k*CPB+j] !== bits[k]) begin
          n_bad++;
          $display("FAIL 8n1_bit%0d cyc%0d: txd=%b required %b", k, j, rec_txd[0][k*CPB+j], bits[k]);
        end
      end
    end
    n_cmp++;
    if (rec_busy[0] != 40 || rec_done[0] != 1 || rec_done_at[0] != 39) begin
      n_bad++;
      $display("FAIL 8n1_timing: busy_cycles=%0d done_pulses=%0d done_at=%0d, required 40 1 39",
               rec_busy[0], rec_done[0], rec_done_at[0]);
    end
  endtask

  task automatic test_parity_and_width();
    push_byte(8'hA5);
    run_cycles(50);
    n_cmp++;
    if (rec_txd[1][9*CPB+2] !== 1'b0 || rec_busy[1] != 44) begin
      n_bad++;
      $display("FAIL even_parity: parity=%b busy_cycles=%0d, required 0 44", rec_txd[1][9*CPB+2], rec_busy[1]);
    end
    n_cmp++;
    if (rec_txd[2][9*CPB+2] !== 1'b1 || rec_busy[2] != 44 || rec_done_at[2] != 43) begin
      n_bad++;
      $display("FAIL odd_parity: parity=%b busy_cycles=%0d done_at=%0d, required 1 44 43",
               rec_txd[2][9*CPB+2], rec_busy[2], rec_done_at[2]);
    end
    push_byte(8'hFF);
    run_cycles(50);
    n_cmp++;
    if (rec_busy[3] != 36 || rec_low[3] != CPB || rec_done_at[3] != 35) begin
      n_bad++;
      $display("FAIL 7n1_frame: busy_cycles=%0d low_cycles=%0d done_at=%0d, required 36 4 35",
               rec_busy[3], rec_low[3], rec_done_at[3]);
    end
    n_cmp++;
    if (rec_txd[1][9*CPB+2] !== 1'b0 || rec_txd[2][9*CPB+2] !== 1'b1) begin
      n_bad++;
      $display("FAIL parity_ff: even=%b odd=%b, required 0 1", rec_txd[1][9*CPB+2], rec_txd[2][9*CPB+2]);
    end
  endtask

  task automatic test_two_stop();
    int highs;
    push_byte(8'h00);
    run_cycles(50);
    highs = 0;
    for (int c = 36; c < 44; c++) if (rec_txd[4][c] === 1'b1) highs++;
    n_cmp++;
    if (highs != 8 || rec_low[4] != 36 || rec_busy[4] != 44 || rec_done_at[4] != 43) begin
      n_bad++;
      $display("FAIL 8n2_stop: stop_highs=%0d low_cycles=%0d busy_cycles=%0d done_at=%0d, required 8 36 44 43",
               highs, rec_low[4], rec_busy[4], rec_done_at[4]);
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] v;
    tx_en = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      in_data = 8'(n); in_valid = 1'b1;
      tick();
      n_cmp++;
      if (rdy_w[0] !== ((n < 4) ? 1'b1 : 1'b0)) begin
        n_bad++;
        $display("FAIL fill_ready after push %0d: in_ready=%b required %b", n, rdy_w[0], (n < 4));
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if (cnt_w[i] !== 3'd4 || busy_w[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL fill_count inst%0d: cnt=%0d busy=%b, required 4 0", i, cnt_w[i], busy_w[i]);
      end
    end
    tx_en = 1'b1;
    run_cycles(200);
    n_cmp++;
    if (rec_done[0] != 4 || rec_fall[0] != 1 || rec_busy[0] != 160 || rec_busy[4] != 176) begin
      n_bad++;
      $display("FAIL back_to_back: done=%0d falls=%0d busy0=%0d busy4=%0d, required 4 1 160 176",
               rec_done[0], rec_fall[0], rec_busy[0], rec_busy[4]);
    end
    for (int f = 0; f < 4; f++) begin
      v = 8'(f + 1);
      for (int k = 0; k < 8; k++) begin
        n_cmp++;
        if (rec_txd[0][f*40 + (1+k)*CPB + 2] !== v[k]) begin
          n_bad++;
          $display("FAIL drain_frame%0d_bit%0d: txd=%b required %b", f, k, rec_txd[0][f*40+(1+k)*CPB+2], v[k]);
        end
      end
    end
    n_cmp++;
    if (cnt_w[0] !== 3'd0 || rdy_w[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL drained: cnt=%0d rdy=%b, required 0 1", cnt_w[0], rdy_w[0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    run_cycles(10);
    n_cmp++;
    if (cnt_w[0] !== 3'd2 || busy_w[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_abort: cnt=%0d busy=%b, required 2 1", cnt_w[0], busy_w[0]);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if (txd_w[i] !== 1'b1 || busy_w[i] !== 1'b0 || cnt_w[i] !== 3'd0 || rdy_w[i] !== 1'b1) begin
        n_bad++;
        $display("FAIL abort inst%0d: txd=%b busy=%b cnt=%0d rdy=%b, required 1 0 0 1",
                 i, txd_w[i], busy_w[i], cnt_w[i], rdy_w[i]);
      end
    end
    run_cycles(100);
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if (rec_busy[i] != 0 || rec_low[i] != 0) begin
        n_bad++;
        $display("FAIL post_abort inst%0d: busy_cycles=%0d low_cycles=%0d, required 0 0", i, rec_busy[i], rec_low[i]);
      end
    end
  endtask

  task automatic test_simultaneous_push_pop();
    logic [7:0] a, b;
    a = 8'h3C; b = 8'hC3;
    in_data = a; in_valid = 1'b1;
    tick();
    in_data = b;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (cnt_w[0] !== 3'd1 || busy_w[0] !== 1'b1 || txd_w[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL push_pop: cnt=%0d busy=%b txd=%b, required 1 1 0", cnt_w[0], busy_w[0], txd_w[0]);
    end
    run_cycles(100);
    n_cmp++;
    if (rec_done[0] != 2 || rec_fall[0] != 1 || rec_busy[0] != 79) begin
      n_bad++;
      $display("FAIL push_pop_frames: done=%0d falls=%0d busy_cycles=%0d, required 2 1 79",
               rec_done[0], rec_fall[0], rec_busy[0]);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (rec_txd[0][39 + (1+k)*CPB + 2] !== b[k]) begin
        n_bad++;
        $display("FAIL second_frame_bit%0d: txd=%b required %b", k, rec_txd[0][39+(1+k)*CPB+2], b[k]);
      end
    end
  endtask

  task automatic test_random();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(2) == 0);
      in_data  = 8'($urandom);
      if (c % 50 == 0) tx_en = ($urandom_range(3) != 0);
      rst_n = ($urandom_range(499) != 0);
      tick();
      for (int i = 0; i < NI; i++) begin
        n_cmp++;
        if (txd_w[i] !== exp_txd(i) || busy_w[i] !== m_act[i] || done_w[i] !== exp_done(i) ||
            cnt_w[i] !== 3'(m_size[i]) || rdy_w[i] !== (m_size[i] < DEPTH)) begin
          n_bad++;
          $display("FAIL random inst%0d cyc%0d: txd/busy/done/cnt/rdy=%b/%b/%b/%0d/%b required %b/%b/%b/%0d/%b",
                   i, c, txd_w[i], busy_w[i], done_w[i], cnt_w[i], rdy_w[i],
                   exp_txd(i), m_act[i], exp_done(i), m_size[i], (m_size[i] < DEPTH));
        end
      end
    end
    rst_n = 1'b1; in_valid = 1'b0; tx_en = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_size[i] = 0; m_act[i] = 1'b0; m_pos[i] = 0; m_cur[i] = 8'h00;
    end
    test_reset();
    test_8n1_frame();
    test_parity_and_width();
    test_two_stop();
    test_fifo_full();
    test_reset_mid_frame();
    test_simultaneous_push_pop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion before it");
    $fatal(1, "watchdog");
  end

endmodule
